// File: rtl/tpu_tile_sequencer_pkg.sv
// Shared definitions for the TPU tile controllers: default geometry, the
// controller state encoding and the array latency expression.
package tpu_tile_sequencer_pkg;

    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_NUM_PE_ROWS = 8;
    localparam int DEF_UB_RD_LAT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WFETCH = 3'd1,
        ST_WLOAD  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FIN    = 3'd5
    } seq_state_e;

    // Skew in plus de-skew out of a weight-stationary array.
    function automatic int array_lat(input int matrix_size, input int num_pe_rows);
        return matrix_size + num_pe_rows;
    endfunction

endpackage

// File: rtl/tpu_tile_sequencer_valid_delay.sv
// Valid-bit delay line with synchronous flush. any_valid_o reports bits that
// still have at least one stage to travel, so a drain can end as the last
// bit leaves the final stage.
module tpu_valid_delay #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o,
    output logic any_valid_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift in the new valid bit, or clear the whole line on flush.
    always_comb begin
        sr_d = sr_q;
        if (flush_i) begin
            sr_d = {DEPTH{1'b0}};
        end else begin
            sr_d = {sr_q[DEPTH-2:0], valid_i};
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q <= {DEPTH{1'b0}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign valid_o     = sr_q[DEPTH-1];
    assign any_valid_o = valid_i | (|sr_q[DEPTH-2:0]);

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Autonomous sequencer for one weight-stationary matmul tile: weight fetch,
// array reload, input streaming from the UB and result write-back.
module tpu_tile_sequencer
    import tpu_tile_sequencer_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int NUM_PE_ROWS = DEF_NUM_PE_ROWS,
    parameter int UB_RD_LAT   = DEF_UB_RD_LAT,
    parameter int ARRAY_LAT   = array_lat(MATRIX_SIZE, NUM_PE_ROWS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] num_rows,
    input  logic [ADDRESSSIZE-1:0] src_base,
    input  logic [ADDRESSSIZE-1:0] dst_base,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done
);

    // The res_we output register supplies the final cycle of the delay.
    localparam int DLY_DEPTH = UB_RD_LAT + ARRAY_LAT - 1;
    localparam logic [ADDRESSSIZE-1:0] ONE_A  = ADDRESSSIZE'(1);
    localparam logic [ADDRESSSIZE-1:0] ZERO_A = ADDRESSSIZE'(0);

    seq_state_e             state_q, state_d;
    logic [ADDRESSSIZE-1:0] rows_q, rows_d;
    logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
    logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
    logic                   fifo_re_q, fifo_re_d;
    logic                   we_rl_q, we_rl_d;
    logic                   ub_rd_en_q, ub_rd_en_d;
    logic                   res_we_q, res_we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   flush_s;
    logic                   dly_out_s;
    logic                   dly_any_s;

    tpu_valid_delay #(
        .DEPTH (DLY_DEPTH)
    ) u_valid_delay (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_s),
        .valid_i     (ub_rd_en_q),
        .valid_o     (dly_out_s),
        .any_valid_o (dly_any_s)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        fifo_re_d  = 1'b0;
        we_rl_d    = 1'b0;
        ub_rd_en_d = 1'b0;
        done_d     = 1'b0;
        flush_s    = 1'b0;
        ub_addr_d  = ub_rd_en_q ? (ub_addr_q + ONE_A) : ub_addr_q;
        res_addr_d = res_we_q ? (res_addr_q + ONE_A) : res_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rows_d     = num_rows;
                    ub_addr_d  = src_base;
                    res_addr_d = dst_base;
                    state_d    = (num_rows == ZERO_A) ? ST_FIN : ST_WFETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WFETCH: begin
                if (!fifo_empty) begin
                    fifo_re_d = 1'b1;
                    state_d   = ST_WLOAD;
                end else begin
                    state_d = ST_WFETCH;
                end
            end
            ST_WLOAD: begin
                we_rl_d = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                ub_rd_en_d = 1'b1;
                rows_d     = rows_q - ONE_A;
                if (rows_q == ONE_A) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (!dly_any_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel squashes every pulse of the current cycle and empties the pipe.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            fifo_re_d  = 1'b0;
            we_rl_d    = 1'b0;
            ub_rd_en_d = 1'b0;
            done_d     = 1'b0;
            flush_s    = 1'b1;
        end else begin
            flush_s = 1'b0;
        end

        res_we_d = flush_s ? 1'b0 : dly_out_s;
        busy_d   = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rows_q     <= ZERO_A;
            ub_addr_q  <= ZERO_A;
            res_addr_q <= ZERO_A;
            fifo_re_q  <= 1'b0;
            we_rl_q    <= 1'b0;
            ub_rd_en_q <= 1'b0;
            res_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            ub_addr_q  <= ub_addr_d;
            res_addr_q <= res_addr_d;
            fifo_re_q  <= fifo_re_d;
            we_rl_q    <= we_rl_d;
            ub_rd_en_q <= ub_rd_en_d;
            res_we_q   <= res_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_read_enable = fifo_re_q;
    assign we_rl            = we_rl_q;
    assign ub_rd_en         = ub_rd_en_q;
    assign ub_addr          = ub_addr_q;
    assign res_we           = res_we_q;
    assign res_addr         = res_addr_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
